// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like port (req/addr_ok/data_ok) between
// instruction fetch (I) and the data port (D). Address phases are arbitrated,
// a started handshake keeps its grant until accepted, and an in-order owner
// FIFO steers each returning data_ok to the master that issued the request.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// conflicts. Without it, D has fixed priority over I.
module sram_port_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int OID_W       = 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           i_req,
    input  logic                           i_wr,
    input  logic [1:0]                     i_size,
    input  logic [3:0]                     i_wstrb,
    input  logic [31:0]                    i_addr,
    input  logic [31:0]                    i_wdata,
    output logic                           i_addr_ok,
    output logic                           i_data_ok,
    output logic [31:0]                    i_rdata,
    input  logic                           d_req,
    input  logic                           d_wr,
    input  logic [1:0]                     d_size,
    input  logic [3:0]                     d_wstrb,
    input  logic [31:0]                    d_addr,
    input  logic [31:0]                    d_wdata,
    output logic                           d_addr_ok,
    output logic                           d_data_ok,
    output logic [31:0]                    d_rdata,
    output logic                           s_req,
    output logic                           s_wr,
    output logic [1:0]                     s_size,
    output logic [3:0]                     s_wstrb,
    output logic [31:0]                    s_addr,
    output logic [31:0]                    s_wdata,
    input  logic                           s_addr_ok,
    input  logic                           s_data_ok,
    input  logic [31:0]                    s_rdata,
    output logic [$clog2(OUTSTANDING):0]   outstanding_cnt
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [OID_W-1:0] OID_I = '0;
    localparam logic [OID_W-1:0] OID_D = OID_W'(1);

    // Lock state: once a request is presented but not yet accepted, the
    // selection is frozen on that master so the slave sees stable fields.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK_I   = 2'd1,
        LOCK_D   = 2'd2
    } lock_e;

    lock_e            lock_q;
    lock_e            lock_d;

    logic [OID_W-1:0] owner_q [OUTSTANDING];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    wrPtr_d;
    logic [PW-1:0]    rdPtr_q;
    logic [PW-1:0]    rdPtr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic             grantD;
    logic             selReq;
    logic             full;
    logic             sReqInt;
    logic             push;
    logic             pop;
    logic [OID_W-1:0] headOwner;
    logic [OID_W-1:0] grantOwner;

`ifdef ARB_ROUND_ROBIN_EN
    // Preferred master on a conflict: 1 means D wins, 0 means I wins.
    logic             prioD_q;
    logic             prioD_d;

    // After every accepted address phase the other master gets preference.
    always_comb begin
        prioD_d = prioD_q;
        if (push) begin
            prioD_d = ~grantD;
        end
    end

    // Preference register, starting with D preferred out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prioD_q <= 1'b1;
        end else begin
            prioD_q <= prioD_d;
        end
    end
`endif

    // Choose which master drives the slave port this cycle. An idle port
    // defaults to D so the slave fields follow the data master.
    always_comb begin
        grantD = 1'b1;
        case (lock_q)
            LOCK_I:  grantD = 1'b0;
            LOCK_D:  grantD = 1'b1;
            default: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (d_req && i_req) begin
                    grantD = prioD_q;
                end else begin
                    grantD = d_req || !i_req;
                end
`else
                grantD = d_req || !i_req;
`endif
            end
        endcase
    end

    assign selReq     = grantD ? d_req : i_req;
    assign full       = (cnt_q == CW'(OUTSTANDING));
    assign sReqInt    = selReq && !full && resetn;
    assign push       = sReqInt && s_addr_ok;
    assign pop        = s_data_ok && resetn && (cnt_q != '0);
    assign headOwner  = owner_q[rdPtr_q];
    assign grantOwner = grantD ? OID_D : OID_I;

    assign s_req      = sReqInt;
    assign s_wr       = grantD ? d_wr    : i_wr;
    assign s_size     = grantD ? d_size  : i_size;
    assign s_wstrb    = grantD ? d_wstrb : i_wstrb;
    assign s_addr     = grantD ? d_addr  : i_addr;
    assign s_wdata    = grantD ? d_wdata : i_wdata;

    assign i_addr_ok  = push && !grantD;
    assign d_addr_ok  = push && grantD;

    assign i_data_ok  = pop && (headOwner == OID_I);
    assign d_data_ok  = pop && (headOwner == OID_D);
    assign i_rdata    = s_rdata;
    assign d_rdata    = s_rdata;

    assign outstanding_cnt = cnt_q;

    // Lock tracking: a pending unaccepted request locks the grant; acceptance
    // unlocks it; a locked master dropping its request leaves the lock intact.
    always_comb begin
        lock_d = lock_q;
        if (sReqInt) begin
            if (s_addr_ok) begin
                lock_d = UNLOCKED;
            end else if (grantD) begin
                lock_d = LOCK_D;
            end else begin
                lock_d = LOCK_I;
            end
        end
    end

    // Owner FIFO pointers and occupancy. A push and a pop in the same cycle
    // leave the count unchanged; a fresh push is never the entry being popped
    // because pop only looks at the pre-existing head.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        cnt_d   = cnt_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control registers: lock state, FIFO pointers and in-flight count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q  <= UNLOCKED;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            cnt_q   <= '0;
        end else begin
            lock_q  <= lock_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Owner storage; contents only matter while the count says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_q[wrPtr_q] <= grantOwner;
        end
    end

endmodule
